pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the pipelined MIPS CPU. Holds the program counter, selects the next PC (sequential, j/jal, jr, taken branch), and owns the IF/ID pipeline register. Consumes the 28-bit shifted jump field from the ID-stage jump shifter and drives the instruction-memory address. Supports stall (hold) and flush (bubble insertion) from the hazard unit.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `CNT_W`, default 16: width of the saturating redirect counter.

- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `instr_i`  in  32  instruction word from instruction memory (combinational read of `pc_o`).
- `pc_write_i`  in  1  1 = PC may advance; 0 = stall, hold PC.
- `ifid_write_i`  in  1  1 = IF/ID may load; 0 = hold IF/ID.
- `jump_i`  in  1  ID-stage j/jal decoded.
- `jump_addr_i`  in  28  shifted jump field, `{instr[25:0], 2'b00}`.
- `jr_i`  in  1  ID-stage jr decoded.
- `jr_addr_i`  in  32  register target for jr.
- `branch_taken_i`  in  1  EX-stage branch resolved taken.
- `branch_target_i`  in  32  EX-stage branch target.
- `pc_o`  out  32  current PC, to instruction memory.
- `ifid_pc4_o`  out  32  PC+4 of instruction held in IF/ID.
- `ifid_instr_o`  out  32  instruction held in IF/ID.
- `ifid_valid_o`  out  1  IF/ID holds a real instruction (0 = bubble).
- `redirect_cnt_o`  out  CNT_W  number of applied redirects, saturating.

## Operation
- Next-PC priority (highest first): `branch_taken_i` → `branch_target_i`; `jr_i` → `jr_addr_i`; `jump_i` → `{ifid_pc4_o[31:28], jump_addr_i}`; else `pc_o + 4`.
- PC+4 is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- PC bits [1:0] always 0; bits [1:0] of `jr_addr_i` and `branch_target_i` are discarded.
- Stall: `pc_write_i`=0 holds PC. Taken branch overrides stall (EX is older than stalled ID); jr/jump are ignored while `pc_write_i`=0 (ID re-presents them).
- A redirect is "applied" when branch is taken, or jr/jump with `pc_write_i`=1.
- IF/ID: on applied redirect, load bubble (`ifid_instr_o`=32'h0, `ifid_valid_o`=0, `ifid_pc4_o`=0) regardless of `ifid_write_i`. Else if `ifid_write_i`=1 load `instr_i`, `pc_o+4`, valid=1. Else hold.
- `redirect_cnt_o` increments by 1 per applied redirect; holds at all-ones.
- Reset (any time, including mid-redirect or mid-stall): `pc_o`=RESET_PC, IF/ID = bubble, `redirect_cnt_o`=0, effective immediately, independent of clock.

## Timing
- All state updates on rising `clk_i`; outputs are registered, no combinational input→output paths.
- Redirect latency: inputs sampled at edge N → `pc_o` = target after edge N; instruction fetched in the shadow slot is replaced by the bubble at edge N.
- Sequential fetch: one instruction per cycle into IF/ID when no stall.
- First edge after reset release loads the instruction at RESET_PC into IF/ID.

## Structure
- Shared package `cpu_pkg`: `NOP_INSTR` (32'h0), default `RESET_PC`, next-PC select enum {SEL_SEQ, SEL_JUMP, SEL_JR, SEL_BRANCH}.
- One sub-module `pc_next_mux`: combinational priority select and target formation (inputs: pc, ifid_pc4, requests, targets, pc_write; outputs: next_pc, select, redirect). Top holds the PC, IF/ID, and counter registers.

## Test plan
- Reset then free-run with RESET_PC=0: `pc_o` 0,4,8,12 on successive edges; IF/ID pc4 lags one cycle (4,8,12), valid=1 from first edge.
- `jump_i`=1, `jump_addr_i`=28'h0000_040, `ifid_pc4_o`=32'h1000_0008 → next `pc_o`=32'h1000_0040, IF/ID bubble, `redirect_cnt_o`=1.
- Simultaneous `branch_taken_i` (target 32'h0000_0100) and `jr_i` (32'h0000_0200) with `pc_write_i`=0 → `pc_o`=32'h100, bubble; same jr alone with `pc_write_i`=0 → PC and IF/ID hold, counter unchanged.
- `pc_o`=32'hFFFF_FFFC, no redirect → next `pc_o`=0; `jr_addr_i`=32'h0000_0203 → `pc_o`=32'h0000_0200.
- Assert `rst_i`=0 mid-cycle during stall after three redirects → `pc_o`=RESET_PC, `ifid_valid_o`=0, `redirect_cnt_o`=0 before next edge.
- With CNT_W=2, apply 5 redirects → `redirect_cnt_o` 1,2,3,3,3.

Source files
------------

// File: rtl/cpu_pkg.sv
// Definitions shared by the MIPS pipeline front end: the NOP encoding,
// the default reset vector and the next-PC source select.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_JUMP,
        SEL_JR,
        SEL_BRANCH
    } pc_sel_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC priority select and redirect-target formation for the fetch stage.
module pc_next_mux
    import cpu_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [3:0]  ifid_pc4_hi_i,
    input  logic        pc_write_i,
    input  logic        jump_i,
    input  logic [27:0] jump_addr_i,
    input  logic        jr_i,
    input  logic [31:0] jr_addr_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] next_pc_o,
    output pc_sel_e     sel_o,
    output logic        redirect_o
);

    logic [31:0] pc_plus4;

    assign pc_plus4 = pc_i + 32'd4;

    // A resolved branch comes from EX and is older than the stalled ID
    // instruction, so it wins even when the PC is otherwise held.
    always_comb begin
        sel_o     = SEL_SEQ;
        next_pc_o = pc_write_i ? pc_plus4 : pc_i;
        if (branch_taken_i) begin
            sel_o     = SEL_BRANCH;
            next_pc_o = word_align(branch_target_i);
        end else if (pc_write_i && jr_i) begin
            sel_o     = SEL_JR;
            next_pc_o = word_align(jr_addr_i);
        end else if (pc_write_i && jump_i) begin
            sel_o     = SEL_JUMP;
            next_pc_o = word_align({ifid_pc4_hi_i, jump_addr_i});
        end
    end

    assign redirect_o = (sel_o != SEL_SEQ);

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register and a
// saturating count of applied control-flow redirects.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      instr_i,
    input  logic             pc_write_i,
    input  logic             ifid_write_i,
    input  logic             jump_i,
    input  logic [27:0]      jump_addr_i,
    input  logic             jr_i,
    input  logic [31:0]      jr_addr_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc4_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    localparam logic [31:0]      RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [CNT_W-1:0] CNT_MAX          = '1;
    localparam logic [CNT_W-1:0] CNT_ONE          = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc4_q, ifid_pc4_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] next_pc_w;
    pc_sel_e     sel_w;
    logic        redirect_w;
    logic [31:0] pc_plus4_w;

    assign pc_plus4_w = pc_q + 32'd4;

    pc_next_mux u_pc_next_mux (
        .pc_i            (pc_q),
        .ifid_pc4_hi_i   (ifid_pc4_q[31:28]),
        .pc_write_i      (pc_write_i),
        .jump_i          (jump_i),
        .jump_addr_i     (jump_addr_i),
        .jr_i            (jr_i),
        .jr_addr_i       (jr_addr_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .next_pc_o       (next_pc_w),
        .sel_o           (sel_w),
        .redirect_o      (redirect_w)
    );

    // The instruction fetched in the redirect shadow is on the wrong path,
    // so a redirect squashes IF/ID even if the hazard unit asked to hold it.
    always_comb begin
        pc_d         = next_pc_w;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        cnt_d        = cnt_q;
        if (sel_w != SEL_SEQ) begin
            ifid_pc4_d   = 32'h0000_0000;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (ifid_write_i) begin
            ifid_pc4_d   = pc_plus4_w;
            ifid_instr_d = instr_i;
            ifid_valid_d = 1'b1;
        end
        if (redirect_w && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q         <= RESET_PC_ALIGNED;
            ifid_pc4_q   <= 32'h0000_0000;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign ifid_pc4_o     = ifid_pc4_q;
    assign ifid_instr_o   = ifid_instr_q;
    assign ifid_valid_o   = ifid_valid_q;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized traffic checked
// against a behavioural model of the fetch stage.
module tb_pc_fetch_unit;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] instr_i, instr2_i;
    logic        pc_write_i, ifid_write_i;
    logic        jump_i;
    logic [27:0] jump_addr_i;
    logic        jr_i;
    logic [31:0] jr_addr_i;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;

    logic [31:0] pc_o, ifid_pc4_o, ifid_instr_o;
    logic        ifid_valid_o;
    logic [15:0] redirect_cnt_o;

    logic [31:0] pc2_o, ifid_pc4_2_o, ifid_instr_2_o;
    logic        ifid_valid_2_o;
    logic [1:0]  redirect_cnt_2_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mPc, mIfPc4, mIfInstr;
    logic        mIfValid;
    int          mCnt;

    function automatic logic [31:0] imem(input logic [31:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A5A_0000;
    endfunction

    assign instr_i  = imem(pc_o);
    assign instr2_i = imem(pc2_o);

    pc_fetch_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i),
        .pc_write_i(pc_write_i), .ifid_write_i(ifid_write_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .jr_i(jr_i), .jr_addr_i(jr_addr_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(pc_o), .ifid_pc4_o(ifid_pc4_o), .ifid_instr_o(ifid_instr_o),
        .ifid_valid_o(ifid_valid_o), .redirect_cnt_o(redirect_cnt_o)
    );

    pc_fetch_unit #(.CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr2_i),
        .pc_write_i(pc_write_i), .ifid_write_i(ifid_write_i),
        .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .jr_i(jr_i), .jr_addr_i(jr_addr_i),
        .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
        .pc_o(pc2_o), .ifid_pc4_o(ifid_pc4_2_o), .ifid_instr_o(ifid_instr_2_o),
        .ifid_valid_o(ifid_valid_2_o), .redirect_cnt_o(redirect_cnt_2_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic setIdle();
        pc_write_i      = 1'b1;
        ifid_write_i    = 1'b1;
        jump_i          = 1'b0;
        jump_addr_i     = 28'h0;
        jr_i            = 1'b0;
        jr_addr_i       = 32'h0;
        branch_taken_i  = 1'b0;
        branch_target_i = 32'h0;
    endtask

    task automatic modelReset();
        mPc      = 32'h0;
        mIfPc4   = 32'h0;
        mIfInstr = 32'h0;
        mIfValid = 1'b0;
        mCnt     = 0;
    endtask

    // One rising edge: the model applies the fetch-stage rules to the inputs
    // present at the edge, then outputs are left to settle before sampling.
    task automatic tick();
        logic        applied;
        logic [31:0] nextPc;
        @(posedge clk_i);
        applied = branch_taken_i || (pc_write_i && (jr_i || jump_i));
        if (branch_taken_i)            nextPc = branch_target_i & 32'hFFFF_FFFC;
        else if (pc_write_i && jr_i)   nextPc = jr_addr_i & 32'hFFFF_FFFC;
        else if (pc_write_i && jump_i) nextPc = {mIfPc4[31:28], jump_addr_i};
        else if (pc_write_i)           nextPc = mPc + 32'd4;
        else                           nextPc = mPc;
        if (applied) begin
            mIfPc4 = 32'h0; mIfInstr = 32'h0; mIfValid = 1'b0;
        end else if (ifid_write_i) begin
            mIfPc4 = mPc + 32'd4; mIfInstr = imem(mPc); mIfValid = 1'b1;
        end
        if (applied) mCnt++;
        mPc = nextPc;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        setIdle();
        modelReset();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        setIdle();
        modelReset();
        #22;
        checks++; if (pc_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h expected %h", pc_o, 32'h0); end
        checks++; if (ifid_valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b expected 0", ifid_valid_o); end
        checks++; if (ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin failures++; $display("[TB] FAIL reset_ifid got %h/%h expected 0/0", ifid_instr_o, ifid_pc4_o); end
        checks++; if (redirect_cnt_o !== 16'h0) begin failures++; $display("[TB] FAIL reset_cnt got %h expected 0", redirect_cnt_o); end
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 3; k++) begin
            tick();
            checks++; if (pc_o !== 32'(4 * k)) begin failures++; $display("[TB] FAIL seq_pc[%0d] got %h expected %h", k, pc_o, 32'(4 * k)); end
            checks++; if (ifid_pc4_o !== 32'(4 * k) || ifid_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL seq_ifid[%0d] got pc4=%h v=%b expected pc4=%h v=1", k, ifid_pc4_o, ifid_valid_o, 32'(4 * k)); end
            checks++; if (ifid_instr_o !== imem(32'(4 * (k - 1)))) begin failures++; $display("[TB] FAIL seq_instr[%0d] got %h expected %h", k, ifid_instr_o, imem(32'(4 * (k - 1)))); end
        end
    endtask

    task automatic test_jump();
        doReset();
        jr_i = 1'b1; jr_addr_i = 32'h1000_0004;
        tick();
        setIdle();
        tick();
        checks++; if (ifid_pc4_o !== 32'h1000_0008) begin failures++; $display("[TB] FAIL jump_setup got %h expected %h", ifid_pc4_o, 32'h1000_0008); end
        jump_i = 1'b1; jump_addr_i = 28'h000_0040;
        tick();
        setIdle();
        checks++; if (pc_o !== 32'h1000_0040) begin failures++; $display("[TB] FAIL jump_pc got %h expected %h", pc_o, 32'h1000_0040); end
        checks++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0 || ifid_pc4_o !== 32'h0) begin failures++; $display("[TB] FAIL jump_bubble got v=%b i=%h p=%h expected bubble", ifid_valid_o, ifid_instr_o, ifid_pc4_o); end
        checks++; if (redirect_cnt_o !== 16'd2) begin failures++; $display("[TB] FAIL jump_cnt got %0d expected 2", redirect_cnt_o); end
    endtask

    task automatic test_branch_priority();
        doReset();
        pc_write_i = 1'b0;
        branch_taken_i = 1'b1; branch_target_i = 32'h0000_0100;
        jr_i = 1'b1; jr_addr_i = 32'h0000_0200;
        tick();
        setIdle();
        checks++; if (pc_o !== 32'h100) begin failures++; $display("[TB] FAIL brprio_pc got %h expected %h", pc_o, 32'h100); end
        checks++; if (ifid_valid_o !== 1'b0 || redirect_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL brprio_bubble got v=%b cnt=%0d expected v=0 cnt=1", ifid_valid_o, redirect_cnt_o); end
        tick();
        pc_write_i = 1'b0; ifid_write_i = 1'b0;
        jr_i = 1'b1; jr_addr_i = 32'h0000_0200;
        tick();
        tick();
        setIdle();
        checks++; if (pc_o !== 32'h104) begin failures++; $display("[TB] FAIL stall_jr_pc got %h expected %h", pc_o, 32'h104); end
        checks++; if (ifid_valid_o !== 1'b1 || ifid_pc4_o !== 32'h104 || ifid_instr_o !== imem(32'h100)) begin failures++; $display("[TB] FAIL stall_jr_ifid got v=%b p=%h i=%h expected v=1 p=104 i=%h", ifid_valid_o, ifid_pc4_o, ifid_instr_o, imem(32'h100)); end
        checks++; if (redirect_cnt_o !== 16'd1) begin failures++; $display("[TB] FAIL stall_jr_cnt got %0d expected 1", redirect_cnt_o); end
    endtask

    task automatic test_wrap();
        jr_i = 1'b1; jr_addr_i = 32'hFFFF_FFFF;
        tick();
        setIdle();
        checks++; if (pc_o !== 32'hFFFF_FFFC) begin failures++; $display("[TB] FAIL wrap_setup got %h expected %h", pc_o, 32'hFFFF_FFFC); end
        tick();
        checks++; if (pc_o !== 32'h0 || ifid_pc4_o !== 32'h0 || ifid_valid_o !== 1'b1) begin failures++; $display("[TB] FAIL wrap_pc got pc=%h p4=%h v=%b expected 0/0/1", pc_o, ifid_pc4_o, ifid_valid_o); end
        jr_i = 1'b1; jr_addr_i = 32'h0000_0203;
        tick();
        setIdle();
        checks++; if (pc_o !== 32'h0000_0200) begin failures++; $display("[TB] FAIL jr_align got %h expected %h", pc_o, 32'h200); end
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        jr_i = 1'b1; jr_addr_i = 32'h40;
        tick();
        setIdle(); jump_i = 1'b1; jump_addr_i = 28'h80;
        tick();
        setIdle(); branch_taken_i = 1'b1; branch_target_i = 32'h300;
        tick();
        setIdle(); pc_write_i = 1'b0; ifid_write_i = 1'b0; jr_i = 1'b1; jr_addr_i = 32'h500;
        tick();
        checks++; if (redirect_cnt_o !== 16'd3 || pc_o !== 32'h300) begin failures++; $display("[TB] FAIL prereset got cnt=%0d pc=%h expected 3/300", redirect_cnt_o, pc_o); end
        #2;
        rst_i = 1'b0;
        #1;
        checks++; if (pc_o !== 32'h0 || pc2_o !== 32'h0) begin failures++; $display("[TB] FAIL async_pc got %h/%h expected 0", pc_o, pc2_o); end
        checks++; if (ifid_valid_o !== 1'b0 || ifid_instr_o !== 32'h0) begin failures++; $display("[TB] FAIL async_ifid got v=%b i=%h expected 0/0", ifid_valid_o, ifid_instr_o); end
        checks++; if (redirect_cnt_o !== 16'd0 || redirect_cnt_2_o !== 2'd0) begin failures++; $display("[TB] FAIL async_cnt got %0d/%0d expected 0/0", redirect_cnt_o, redirect_cnt_2_o); end
        modelReset();
        setIdle();
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_saturation();
        logic [1:0] expSat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        doReset();
        for (int k = 0; k < 5; k++) begin
            branch_taken_i = 1'b1; branch_target_i = 32'h1000 + 32'(16 * k);
            tick();
            checks++; if (redirect_cnt_2_o !== expSat[k]) begin failures++; $display("[TB] FAIL sat_cnt2[%0d] got %0d expected %0d", k, redirect_cnt_2_o, expSat[k]); end
            checks++; if (redirect_cnt_o !== 16'(k + 1)) begin failures++; $display("[TB] FAIL sat_cnt16[%0d] got %0d expected %0d", k, redirect_cnt_o, k + 1); end
        end
        setIdle();
    endtask

    task automatic test_random();
        logic [15:0] expCnt;
        logic [1:0]  expCnt2;
        doReset();
        for (int n = 0; n < 400; n++) begin
            pc_write_i      = ($urandom_range(3) != 0);
            ifid_write_i    = ($urandom_range(3) != 0);
            branch_taken_i  = ($urandom_range(7) == 0);
            branch_target_i = $urandom;
            jr_i            = ($urandom_range(7) == 0);
            jr_addr_i       = $urandom;
            jump_i          = ($urandom_range(5) == 0);
            jump_addr_i     = {$urandom_range(32'h3FF_FFFF), 2'b00};
            tick();
            expCnt  = (mCnt > 65535) ? 16'hFFFF : 16'(mCnt);
            expCnt2 = (mCnt > 3) ? 2'd3 : 2'(mCnt);
            checks++; if (pc_o !== mPc || pc2_o !== mPc) begin failures++; $display("[TB] FAIL rnd_pc[%0d] got %h/%h expected %h", n, pc_o, pc2_o, mPc); end
            checks++; if (ifid_pc4_o !== mIfPc4 || ifid_valid_o !== mIfValid) begin failures++; $display("[TB] FAIL rnd_ifid[%0d] got p=%h v=%b expected p=%h v=%b", n, ifid_pc4_o, ifid_valid_o, mIfPc4, mIfValid); end
            checks++; if (ifid_instr_o !== mIfInstr) begin failures++; $display("[TB] FAIL rnd_instr[%0d] got %h expected %h", n, ifid_instr_o, mIfInstr); end
            checks++; if (redirect_cnt_o !== expCnt || redirect_cnt_2_o !== expCnt2) begin failures++; $display("[TB] FAIL rnd_cnt[%0d] got %0d/%0d expected %0d/%0d", n, redirect_cnt_o, redirect_cnt_2_o, expCnt, expCnt2); end
        end
        setIdle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_branch_priority();
        test_wrap();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
